// File: rtl/odd_even_arbiter.sv
// Odd/even parity-alternating round-robin arbiter with a registered one-hot grant.
// Define ODD_EVEN_ARB_TIMEOUT_EN to add a MAX_HOLD grant timeout with a requester mask.
module odd_even_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         ack,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int unsigned IdxW = $clog2(N);

  if (N < 2 || N > 32 || (N % 2) != 0) begin : g_n_check
    $error("odd_even_arbiter: N must be even and within 2..32");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_hold_check
    $error("odd_even_arbiter: MAX_HOLD must be within 1..255");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;  // 0: even group preferred, 1: odd group preferred
  logic [IdxW-1:0] ptr_even_q, ptr_even_d;
  logic [IdxW-1:0] ptr_odd_q, ptr_odd_d;
  logic [IdxW-1:0] gid_q, gid_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [N-1:0]    cand;
  logic [IdxW:0]   pick_even, pick_odd, pick_first, pick_second, win;
  logic            rel;

  // Returns {found, index}; walks the pointer's parity group starting after the pointer.
  function automatic logic [IdxW:0] rr_pick(input logic [N-1:0] r, input logic [IdxW-1:0] ptr);
    logic [IdxW:0]   res;
    int unsigned     pos;
    logic [IdxW-1:0] idx;
    res = '0;
    for (int unsigned k = 1; k <= N / 2; k++) begin
      pos = (32'(ptr) + 2 * k) % N;
      idx = IdxW'(pos);
      if (!res[IdxW] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ODD_EVEN_ARB_TIMEOUT_EN
  logic [7:0]   hold_q, hold_d;
  logic [N-1:0] mask_q, mask_d;
  logic         timeout;

  assign cand    = req & ~mask_q;
  assign timeout = (hold_q >= 8'(MAX_HOLD));
`else
  assign cand = req;
`endif

  assign pick_even   = rr_pick(cand, ptr_even_q);
  assign pick_odd    = rr_pick(cand, ptr_odd_q);
  assign pick_first  = phase_q ? pick_odd : pick_even;
  assign pick_second = phase_q ? pick_even : pick_odd;
  assign win         = pick_first[IdxW] ? pick_first : pick_second;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    ptr_even_d = ptr_even_q;
    ptr_odd_d  = ptr_odd_q;
    gid_d      = gid_q;
    ack_d      = ack_q;
    rel        = 1'b0;
`ifdef ODD_EVEN_ARB_TIMEOUT_EN
    hold_d     = hold_q;
    // A masked requester becomes eligible again once its req is seen low.
    mask_d     = mask_q & req;
`endif
    unique case (state_q)
      StIdle: begin
        if (win[IdxW]) begin
          state_d                = StGrant;
          gid_d                  = win[IdxW-1:0];
          ack_d                  = '0;
          ack_d[win[IdxW-1:0]]   = 1'b1;
`ifdef ODD_EVEN_ARB_TIMEOUT_EN
          hold_d                 = 8'd1;
`endif
        end
      end
      StGrant: begin
        rel = !req[gid_q];
`ifdef ODD_EVEN_ARB_TIMEOUT_EN
        if (!rel && timeout) begin
          rel           = 1'b1;
          mask_d[gid_q] = 1'b1;
        end else if (!rel) begin
          hold_d = hold_q + 8'd1;
        end
`endif
        if (rel) begin
          ack_d   = '0;
          state_d = StIdle;
          phase_d = ~gid_q[0];
          if (gid_q[0]) ptr_odd_d = gid_q;
          else          ptr_even_d = gid_q;
`ifdef ODD_EVEN_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= 1'b0;
      ptr_even_q <= IdxW'(N - 2);
      ptr_odd_q  <= IdxW'(N - 1);
      gid_q      <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ptr_even_q <= ptr_even_d;
      ptr_odd_q  <= ptr_odd_d;
      gid_q      <= gid_d;
      ack_q      <= ack_d;
    end
  end

`ifdef ODD_EVEN_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
      mask_q <= '0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
    end
  end
`endif

  assign ack      = ack_q;
  assign busy     = |ack_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_odd_even_arbiter.sv
// Scoreboard bench for odd_even_arbiter (N=8): a behavioural model pushes expected outputs,
// a monitor pops and compares them one cycle later.
module tb_odd_even_arbiter;

  localparam int N    = 8;
  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] ack;
  logic       busy;
  logic [2:0] grant_id;

  odd_even_arbiter #(
    .N        (N),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ack;
    logic       busy;
    logic [2:0] gid;
  } exp_t;

  exp_t exp_q[$];
  int   got_q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  logic       m_granted;
  int         m_gid;
  int         m_phase;
  int         m_last[2];
  int         m_hold;
  logic [7:0] m_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Closest requester of a parity group after that group's last winner, by circular distance.
  function automatic int pick(input logic [7:0] avail, input int par);
    int best = -1;
    int bestd = N + 1;
    int d;
    for (int i = 0; i < N; i++) begin
      if (avail[i] && (i % 2) == par) begin
        d = (i - m_last[par] + N) % N;
        if (d == 0) d = N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_granted = 1'b0;
    m_gid     = 0;
    m_phase   = 0;
    m_last[0] = N - 2;
    m_last[1] = N - 1;
    m_hold    = 0;
    m_mask    = '0;
  endtask

  task automatic model_release();
    m_granted          = 1'b0;
    m_phase            = 1 - (m_gid % 2);
    m_last[m_gid % 2]  = m_gid;
    m_hold             = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] avail;
    int w;
    avail  = r & ~m_mask;
    m_mask = m_mask & r;
    if (!m_granted) begin
      w = pick(avail, m_phase);
      if (w < 0) w = pick(avail, 1 - m_phase);
      if (w >= 0) begin
        m_granted = 1'b1;
        m_gid     = w;
        m_hold    = 1;
      end
    end else if (!r[m_gid]) begin
      model_release();
    end
`ifdef ODD_EVEN_ARB_TIMEOUT_EN
    else if (m_hold >= MAXH) begin
      m_mask[m_gid] = 1'b1;
      model_release();
    end
`endif
    else begin
      m_hold++;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.ack  = m_granted ? (8'h01 << m_gid) : 8'h00;
    e.busy = m_granted;
    e.gid  = 3'(m_gid);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    push_exp();
  endtask

  // Asserts reset shortly after an edge, checks the asynchronous clear, releases with req=r.
  task automatic do_reset(input logic [7:0] r);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_grant_id", 32'(grant_id), 32'h0);
    exp_q.delete();
    got_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req   = r;
    model_step(r);
    push_exp();
  endtask

  task automatic check_order(input string name, input int expv[$]);
    check({name, "_count"}, 32'(got_q.size()), 32'(expv.size()));
    for (int i = 0; i < expv.size() && i < got_q.size(); i++) begin
      check(name, 32'(got_q[i]), 32'(expv[i]));
    end
  endtask

  // Monitor: compares each cycle against the scoreboard and logs grant starts.
  logic [7:0] prev_ack = '0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ack", 32'(ack), 32'(e.ack));
      check("busy", 32'(busy), 32'(e.busy));
      check("grant_id", 32'(grant_id), 32'(e.gid));
    end
    if (ack != 8'h00 && prev_ack == 8'h00) got_q.push_back(int'(grant_id));
    prev_ack = ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int         order[$];
    rst_n = 1'b0;
    req   = '0;
    model_reset();

    // Idle after reset
    do_reset(8'h00);
    repeat (5) drive(8'h00);

    // Single requester 0, three ack cycles then drop; phase then favours odd
    do_reset(8'h01);
    drive(8'h01);
    drive(8'h01);
    drive(8'h00);
    drive(8'h03);
    drive(8'h00);
    drive(8'h00);

    // Full load with one-cycle grants: strict alternation
    do_reset(8'hFF);
    for (int c = 0; c < 40 && got_q.size() < 9; c++) begin
      r = 8'hFF;
      if (m_granted) r[m_gid] = 1'b0;
      drive(r);
    end
    drive(8'h00);
    order = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    check_order("full_load_order", order);

    // Phase odd, only even requests: even fallback with round-robin
    do_reset(8'h01);
    drive(8'h00);
    for (int c = 0; c < 20 && got_q.size() < 3; c++) begin
      r = 8'h14;
      if (m_granted) r[m_gid] = 1'b0;
      drive(r);
    end
    drive(8'h00);
    drive(8'h00);
    order = '{0, 2, 4};
    check_order("even_fallback_order", order);

    // Reset mid-grant then re-grant on the first edge
    do_reset(8'h08);
    drive(8'h08);
    do_reset(8'h08);
    drive(8'h08);
    drive(8'h00);
    drive(8'h00);

`ifdef ODD_EVEN_ARB_TIMEOUT_EN
    // Timeout after MAX_HOLD cycles; masked until req drops
    do_reset(8'h02);
    repeat (8) drive(8'h02);
    drive(8'h00);
    repeat (3) drive(8'h02);
    drive(8'h00);
    order = '{1, 1};
    check_order("timeout_regrant", order);
`endif

    // Random traffic against the model
    do_reset(8'h00);
    r = 8'h00;
    for (int c = 0; c < 400; c++) begin
      r = r ^ 8'($urandom & $urandom & $urandom);
      if (m_granted && $urandom_range(3) == 0) r[m_gid] = 1'b0;
      drive(r);
    end
    drive(8'h00);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
